// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential add-shift multiplier.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ADD,
    SHIFT,
    DONE
  } mult_state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? int'($clog2(w)) : 1;
  endfunction

endpackage

// File: rtl/addsub_nbit.sv
// Combinational add/subtract on pre-extended operands (add_mode: 1=add, 0=sub).
module addsub_nbit #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add_mode,
  output logic [WIDTH-1:0] sum_c
);

  assign sum_c = add_mode ? (a + b) : (a - b);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential add-shift multiplier; product lands in {Aval, Bval}, X is A's extension bit.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] S,
  input  logic             LoadB,
  input  logic             Start,
  input  logic             Signed,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned EW = WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic             x_q, x_d, sg_q, sg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_d, done_d;

  logic [EW-1:0]    a_ext, m_ext, addsub_sum;
  logic             sub_last;

  // Sign- or zero-extend operands; the final partial product is subtracted in signed mode.
  assign a_ext    = {sg_q & a_q[WIDTH-1], a_q};
  assign m_ext    = {sg_q & m_q[WIDTH-1], m_q};
  assign sub_last = sg_q && (cnt_q == LAST);

  addsub_nbit #(.WIDTH(EW)) u_addsub (
    .a        (a_ext),
    .b        (m_ext),
    .add_mode (~sub_last),
    .sum_c    (addsub_sum)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      x_q     <= 1'b0;
      sg_q    <= 1'b0;
      cnt_q   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      x_q     <= x_d;
      sg_q    <= sg_d;
      cnt_q   <= cnt_d;
      Busy    <= busy_d;
      Done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    x_d     = x_q;
    sg_d    = sg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (LoadB) begin
          b_d = S;
          a_d = '0;
          x_d = 1'b0;
        end else if (Start) begin
          m_d     = S;
          sg_d    = Signed;
          cnt_d   = '0;
          state_d = CLR;
        end
      end
      CLR: begin
        a_d     = '0;
        x_d     = 1'b0;
        state_d = ADD;
      end
      ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = addsub_sum;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        // Unsigned carry is shifted into A once, then cleared so it cannot re-enter.
        x_d = sg_q & x_q;
        a_d = {x_q, a_q[WIDTH-1:1]};
        b_d = {a_q[0], b_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ADD;
        end
      end
      DONE: begin
        if (!Start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLR) || (state_d == ADD) || (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;

endmodule
